// File: rtl/borus_cpu_core_p.sv
// Borus gen-2 CPU core: one instruction per cycle from an external ROM, Z/C flags,
// CALL/RET return stack with overflow/underflow fault, valid/ready I/O ports.
module borus_cpu_core_p #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int NREGS       = 4,
    parameter int STACK_DEPTH = 4,
    localparam int RSEL_W     = $clog2(NREGS),
    localparam int INSTR_W    = 4 + 2 * RSEL_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               halted,
    output logic               fault
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int STK_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [3:0] {
        OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_OUT,
        OP_JMP, OP_JZ,  OP_JC,  OP_CALL, OP_RET, OP_IN, OP_NOP, OP_HLT
    } op_e;

    typedef enum logic [1:0] {S_RUN, S_WAIT_OUT, S_HALT} state_e;

    state_e                               state, state_n;
    logic [ADDR_W-1:0]                    pc, pc_n, pc_inc;
    logic [NREGS-1:0][DATA_W-1:0]         regs;
    logic [STACK_DEPTH-1:0][ADDR_W-1:0]   stack;
    logic [SP_W-1:0]                      sp;
    logic                                 zf, cf;

    op_e               op;
    logic [RSEL_W-1:0] rd_sel, rs_sel;
    logic [DATA_W-1:0] imm, rd_val, rs_val;
    logic [ADDR_W-1:0] target;

    logic [DATA_W-1:0] alu_res, reg_wd;
    logic              alu_c;
    logic              reg_we, flag_we, push, pop, out_ld, out_clr, fault_set;

    assign op         = op_e'(instr_data[INSTR_W-1 -: 4]);
    assign rd_sel     = instr_data[INSTR_W-5 -: RSEL_W];
    assign rs_sel     = instr_data[DATA_W +: RSEL_W];
    assign imm        = instr_data[DATA_W-1:0];
    assign target     = imm[ADDR_W-1:0];
    assign rd_val     = regs[rd_sel];
    assign rs_val     = regs[rs_sel];
    assign pc_inc     = pc + ADDR_W'(1);
    assign instr_addr = pc;

    // SUB's extra MSB is the borrow: set exactly when rd < rs unsigned.
    always_comb begin
        alu_c   = 1'b0;
        alu_res = '0;
        case (op)
            OP_ADD:  {alu_c, alu_res} = {1'b0, rd_val} + {1'b0, rs_val};
            OP_SUB:  {alu_c, alu_res} = {1'b0, rd_val} - {1'b0, rs_val};
            OP_AND:  alu_res = rd_val & rs_val;
            OP_OR:   alu_res = rd_val | rs_val;
            OP_XOR:  alu_res = rd_val ^ rs_val;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        reg_we    = 1'b0;
        reg_wd    = alu_res;
        flag_we   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        out_ld    = 1'b0;
        out_clr   = 1'b0;
        fault_set = 1'b0;
        in_ready  = 1'b0;
        case (state)
            S_RUN: begin
                pc_n = pc_inc;
                case (op)
                    OP_LDI: begin reg_we = 1'b1; reg_wd = imm; end
                    OP_MOV: begin reg_we = 1'b1; reg_wd = rs_val; end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        reg_we  = 1'b1;
                        flag_we = 1'b1;
                    end
                    OP_OUT: begin out_ld = 1'b1; state_n = S_WAIT_OUT; end
                    OP_JMP: pc_n = target;
                    OP_JZ:  if (zf) pc_n = target;
                    OP_JC:  if (cf) pc_n = target;
                    OP_CALL: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            fault_set = 1'b1;
                            pc_n      = pc;
                            state_n   = S_HALT;
                        end else begin
                            push = 1'b1;
                            pc_n = target;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            fault_set = 1'b1;
                            pc_n      = pc;
                            state_n   = S_HALT;
                        end else begin
                            pop  = 1'b1;
                            pc_n = stack[STK_W'(sp - SP_W'(1))];
                        end
                    end
                    OP_IN: begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            reg_we = 1'b1;
                            reg_wd = in_data;
                        end else begin
                            pc_n = pc;
                        end
                    end
                    OP_NOP: ;
                    OP_HLT: state_n = S_HALT;
                endcase
            end
            S_WAIT_OUT: begin
                if (out_valid && out_ready) begin
                    out_clr = 1'b1;
                    state_n = S_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            pc        <= '0;
            regs      <= '0;
            stack     <= '0;
            sp        <= '0;
            zf        <= 1'b0;
            cf        <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            halted <= (state_n == S_HALT);
            if (reg_we) regs[rd_sel] <= reg_wd;
            if (flag_we) begin
                zf <= (alu_res == '0);
                cf <= alu_c;
            end
            if (push) begin
                stack[STK_W'(sp)] <= pc_inc;
                sp                <= sp + SP_W'(1);
            end
            if (pop) sp <= sp - SP_W'(1);
            if (out_ld) begin
                out_data  <= rd_val;
                out_valid <= 1'b1;
            end
            if (out_clr) out_valid <= 1'b0;
            if (fault_set) fault <= 1'b1;
        end
    end
endmodule

// File: doc/borus_cpu_core_p.md
# borus_cpu_core_p

Parametrised second-generation Borus CPU core: configurable data/address width, a small general register file, Z/C flags, conditional jumps, a CALL/RET return stack with fault detection, and valid/ready handshaked I/O ports. It sits between an external combinational program ROM (which it addresses through `instr_addr`) and the surrounding I/O fabric. Execution is one instruction per cycle, except for stalls on I/O handshakes.

## Interface
- `DATA_W`, 8: register, immediate and port width.
- `ADDR_W`, 8: program address width. Must be ≤ `DATA_W`.
- `NREGS`, 4: number of registers. Power of two, ≥ 2. `RSEL_W` = clog2(`NREGS`).
- `STACK_DEPTH`, 4: number of return-stack entries, ≥ 1.
- `INSTR_W`, derived: 4 + 2·`RSEL_W` + `DATA_W` (16 at defaults).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_addr`  out  `ADDR_W`  program counter, driven straight from the PC register.
- `instr_data`  in  `INSTR_W`  ROM word at `instr_addr`, valid in the same cycle.
- `in_data`  in  `DATA_W`  input port data.
- `in_valid`  in  1  input data available.
- `in_ready`  out  1  core consuming input this cycle (combinational).
- `out_data`  out  `DATA_W`  output port data (registered).
- `out_valid`  out  1  output data pending.
- `out_ready`  in  1  sink accepts output.
- `halted`  out  1  core stopped (HLT or fault).
- `fault`  out  1  stack overflow or underflow occurred.

## Operation
- Instruction fields (MSB to LSB):
  - `op` [4 bits]
  - `rd` [`RSEL_W`]
  - `rs` [`RSEL_W`]
  - `imm` [`DATA_W`]
- Jump targets are `imm[ADDR_W-1:0]`.
- Opcodes:
  - 0 LDI: rd ← imm.
  - 1 MOV: rd ← rs.
  - 2 ADD: rd ← rd+rs. C = carry out.
  - 3 SUB: rd ← rd−rs. C = borrow, i.e. C=1 when rd < rs unsigned.
  - 4 AND, 5 OR, 6 XOR: rd ← rd op rs. C ← 0.
  - 7 OUT: see RUN state below.
  - 8 JMP: pc ← imm.
  - 9 JZ: jump if Z.
  - A JC: jump if C.
  - B CALL: push pc+1, then pc ← imm.
  - C RET: pc ← pop.
  - D IN: rd ← `in_data`.
  - E NOP.
  - F HLT.
- Flags:
  - Z is updated by opcodes 2–6 only: Z = (result == 0).
  - C is updated by 2–6 as stated above.
  - No other opcode alters Z or C.
- Arithmetic is modulo 2^`DATA_W`. PC increment is modulo 2^`ADDR_W`, so 2^`ADDR_W`−1 wraps to 0.
- Non-jumping instructions, and jumps whose condition is not taken, set pc ← pc+1.
- FSM states: RUN, WAIT_OUT, HALT.
  - RUN, OUT: `out_data` ← rd, `out_valid` ← 1, pc ← pc+1, go to WAIT_OUT.
  - RUN, IN: `in_ready` = 1. If `in_valid`, rd ← `in_data` and pc ← pc+1. Otherwise hold all state and retry next cycle.
  - RUN, HLT: go to HALT.
  - RUN, CALL with sp == `STACK_DEPTH`: set `fault`, go to HALT. No push; pc unchanged.
  - RUN, RET with sp == 0: set `fault`, go to HALT. pc unchanged.
  - WAIT_OUT: no instruction executes and pc holds. When `out_valid` && `out_ready`: `out_valid` ← 0, go to RUN.
  - HALT: no state changes. `halted` = 1. Only reset exits this state.
- `in_ready` is 0 in every state except RUN with op = IN.
- The return stack holds `STACK_DEPTH` entries of `ADDR_W` bits. sp ranges 0..`STACK_DEPTH`.

## Timing
- Reset values:
  - pc = 0, all registers = 0, Z = C = 0, sp = 0.
  - `out_data` = 0, `out_valid` = 0, `halted` = 0, `fault` = 0, state RUN.
- Reset takes effect immediately on `rst_n` falling, including mid-stall. A pending `out_valid` drops asynchronously.
- Instruction latency: result and pc visible the cycle after the edge that executes the instruction.
- OUT takes at least 2 cycles. If `out_ready` is high during the first WAIT_OUT cycle, the next instruction executes on the following edge.
- `out_data` is stable while `out_valid` = 1.
- IN takes 1 cycle when `in_valid` is already high. Each stall cycle adds one.
- `halted` and `fault` rise on the edge after the HLT or faulting instruction, and stay high until reset.
- Register writes use the pre-edge value of rd and rs. Reading rd == rs is legal.

## Test plan
- Reset then ADD:
  - Stimulus: reset; program LDI r0,0x05; LDI r1,0xFB; ADD r0,r1; OUT r0; HLT; `out_ready`=1.
  - Response: `out_data`=0x00 with `out_valid` high for 1 cycle; Z=1, C=1 (JC path taken in a variant program); `halted`=1 and `fault`=0 after 6 cycles.
- Backpressure:
  - Stimulus: OUT r0 (r0=0xA5) with `out_ready` held low for 5 cycles.
  - Response: `out_valid` high with `out_data`=0xA5 throughout; pc frozen; the next instruction executes only after the ready cycle.
- IN stall:
  - Stimulus: IN r2 with `in_valid` low for 3 cycles, then `in_data`=0x3C.
  - Response: `in_ready` high for 4 cycles; r2=0x3C; pc advances exactly once.
- Stack:
  - Stimulus (nested): nested CALL/RET to depth 4.
  - Response: returns to each CALL+1 in order.
  - Stimulus (overflow): a 5th nested CALL.
  - Response: `fault`=1, `halted`=1, pc = address of the 5th CALL.
  - Stimulus (underflow): RET at sp=0.
  - Response: `fault`=1.
- Loop and wrap:
  - Stimulus: countdown loop LDI r0,3; LDI r1,1; SUB; JZ end; JMP loop.
  - Response: exits after 3 iterations.
  - Stimulus: NOP at address 0xFF.
  - Response: next `instr_addr`=0x00.
- Async reset:
  - Stimulus: assert `rst_n` low mid-WAIT_OUT and while halted.
  - Response: all outputs at reset values immediately; execution restarts from address 0.
